// File: rtl/cam_pixel_capture.sv
// cam_pixel_capture: camera RGB565 byte stream to RGB444 frame-RAM writes, skipping settle frames after reset.
// Define CAP_LINE_CHECK_EN to add the per-line pixel count check on line_err.
module cam_pixel_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SKIP_FRAMES = 2,
  parameter int ADDR_W      = 19
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        data,
  output logic [11:0]       f_data,
  output logic [ADDR_W-1:0] f_addr,
  output logic              out_en,
  output logic              frame_done,
  output logic              overflow,
  output logic              line_err
);
  localparam int PIX = H_ACTIVE * V_ACTIVE;
  localparam int SKW = SKIP_FRAMES > 0 ? $clog2(SKIP_FRAMES + 1) : 1;
  localparam logic [SKW-1:0]    SKIP_LAST = SKW'(SKIP_FRAMES > 0 ? SKIP_FRAMES - 1 : 0);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(PIX - 1);
  typedef enum logic [1:0] {SKIP, WAIT_VS, CAPTURE} state_t;
  state_t r_state, w_nxt;
  logic r_vs, r_vs_d, r_hr, r_phase, r_full;
  logic [7:0] r_d;
  logic [6:0] r_hi;
  logic [SKW-1:0] r_skip;
  logic w_vs_rise, w_vs_fall, w_cap, w_pix;
  assign w_vs_rise = r_vs & ~r_vs_d;
  assign w_vs_fall = ~r_vs & r_vs_d;
  assign w_cap     = r_state == CAPTURE;
  assign w_pix     = w_cap & r_hr & ~r_vs & r_phase;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= SKIP;
    else     r_state <= w_nxt;
  always_comb begin
    w_nxt = r_state;
    if (r_state == SKIP && (SKIP_FRAMES == 0 || (w_vs_rise && r_skip == SKIP_LAST))) w_nxt = WAIT_VS;
    if (r_state == WAIT_VS && w_vs_fall) w_nxt = CAPTURE;
    if (r_state == CAPTURE && w_vs_rise) w_nxt = WAIT_VS;
  end
  // Only the seven hi-byte bits that reach the RGB444 pixel are kept.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {r_vs, r_vs_d, r_hr, r_d, r_hi, r_phase, r_full, r_skip} <= '0;
      f_data     <= '0;
      f_addr     <= '0;
      out_en     <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      r_vs       <= vsync;
      r_vs_d     <= r_vs;
      r_hr       <= href;
      r_d        <= data;
      out_en     <= 1'b0;
      frame_done <= w_cap & w_vs_rise;
      if (frame_done) overflow <= 1'b0;
      if (r_state == SKIP && w_vs_rise) r_skip <= r_skip + 1'b1;
      if (!w_cap) begin
        r_phase <= 1'b0;
        r_full  <= 1'b0;
        f_addr  <= '0;
      end else begin
        r_phase <= r_hr & ~r_vs & ~r_phase;
        if (!r_phase) r_hi <= {r_d[7:4], r_d[2:0]};
        if (w_pix && r_full) overflow <= 1'b1;
        if (w_pix && !r_full) begin
          out_en <= 1'b1;
          f_data <= {r_hi[6:3], r_hi[2:0], r_d[7], r_d[4:1]};
        end
        // Address advances the cycle after each write and parks on the last slot.
        if (out_en) begin
          if (f_addr == ADDR_LAST) r_full <= 1'b1;
          else                     f_addr <= f_addr + 1'b1;
        end
      end
    end
`ifdef CAP_LINE_CHECK_EN
  localparam int LW = $clog2(H_ACTIVE + 1);
  logic r_hr_d;
  logic [LW-1:0] r_lcnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_hr_d   <= 1'b0;
      r_lcnt   <= '0;
      line_err <= 1'b0;
    end else begin
      r_hr_d <= r_hr;
      if (r_hr && !r_hr_d)                  r_lcnt <= '0;
      else if (w_pix && r_lcnt != {LW{1'b1}}) r_lcnt <= r_lcnt + 1'b1;
      if (w_vs_fall) line_err <= 1'b0;
      else if (w_cap && !r_vs && !r_hr && r_hr_d && r_lcnt != LW'(H_ACTIVE)) line_err <= 1'b1;
    end
`else
  assign line_err = 1'b0;
`endif
endmodule

// File: tb/tb_cam_pixel_capture.sv
// tb_cam_pixel_capture: directed bench on a 4x2 frame with two skipped settle frames.
module tb_cam_pixel_capture;
  logic clk = 1'b0, rst = 1'b1, vsync = 1'b0, href = 1'b0;
  logic [7:0] data = 8'h00;
  logic [11:0] f_data;
  logic [18:0] f_addr;
  logic out_en, frame_done, overflow, line_err;
  int total = 0, bad = 0, n_fd = 0;
  int wa[$];
  int wd[$];
  always #5 clk = ~clk;
  cam_pixel_capture #(.H_ACTIVE(4), .V_ACTIVE(2), .SKIP_FRAMES(2), .ADDR_W(19)) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .href(href), .data(data),
    .f_data(f_data), .f_addr(f_addr), .out_en(out_en), .frame_done(frame_done),
    .overflow(overflow), .line_err(line_err)
  );
  always @(negedge clk) begin
    if (out_en) begin
      wa.push_back(int'(f_addr));
      wd.push_back(int'(f_data));
    end
    if (frame_done) n_fd++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic vs, input logic hr, input logic [7:0] d);
    @(negedge clk);
    vsync = vs;
    href  = hr;
    data  = d;
  endtask
  task automatic pix_line(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, 8'((first + i) << 4));
      step(1'b0, 1'b1, 8'h00);
    end
    repeat (3) step(1'b0, 1'b0, 8'h00);
  endtask
  task automatic pulse();
    repeat (3) step(1'b1, 1'b0, 8'h00);
    repeat (2) step(1'b0, 1'b0, 8'h00);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int b, f;
    int ed[6] = '{12'hF00, 12'h0F0, 12'h00F, 12'h100, 12'h200, 12'h400};
    repeat (2) @(negedge clk);
    check("rst_data", f_data, 0);
    check("rst_addr", f_addr, 0);
    check("rst_en", out_en, 0);
    check("rst_fd", frame_done, 0);
    check("rst_ovf", overflow, 0);
    check("rst_lerr", line_err, 0);
    rst = 1'b0;
    b = wa.size(); f = n_fd;
    pix_line(0, 4); pix_line(4, 4); pulse();
    pix_line(0, 4); pix_line(4, 4); pulse();
    check("skip_writes", wa.size() - b, 0);
    check("skip_fd", n_fd - f, 0);
    b = wa.size(); f = n_fd;
    pix_line(0, 4); pix_line(4, 4); pulse();
    check("f3_writes", wa.size() - b, 8);
    check("f3_fd", n_fd - f, 1);
    for (int i = 0; i < 8; i++) begin
      check("f3_addr", wa[b + i], i);
      check("f3_data", wd[b + i], i << 8);
    end
    b = wa.size(); f = n_fd;
    step(1'b0, 1'b1, 8'hF8); step(1'b0, 1'b1, 8'h00); step(1'b0, 1'b1, 8'h07);
    check("lat_early", out_en, 0);
    step(1'b0, 1'b1, 8'hE0);
    check("lat_en", out_en, 1);
    check("lat_data", f_data, 12'hF00);
    check("lat_addr", f_addr, 0);
    step(1'b0, 1'b1, 8'h00); step(1'b0, 1'b1, 8'h1F);
    repeat (3) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h10); step(1'b0, 1'b1, 8'h00); step(1'b0, 1'b1, 8'h20);
    step(1'b0, 1'b1, 8'h00); step(1'b0, 1'b1, 8'h30);
    repeat (3) step(1'b0, 1'b0, 8'h00);
    pix_line(4, 1);
    pulse();
    check("col_writes", wa.size() - b, 6);
    check("col_fd", n_fd - f, 1);
    for (int i = 0; i < 6; i++) begin
      check("col_addr", wa[b + i], i);
      check("col_data", wd[b + i], ed[i]);
    end
    b = wa.size();
    pix_line(0, 4); pix_line(4, 4);
    check("ovf_pre", overflow, 0);
    pix_line(8, 1);
    check("ovf_set", overflow, 1);
    pix_line(9, 1);
    check("ovf_writes", wa.size() - b, 8);
    check("ovf_last_addr", wa[b + 7], 7);
    check("ovf_last_data", wd[b + 7], 12'h700);
    check("ovf_hold_addr", f_addr, 7);
    step(1'b1, 1'b0, 8'h00); step(1'b1, 1'b0, 8'h00);
    check("ovf_fd_early", frame_done, 0);
    step(1'b1, 1'b0, 8'h00);
    check("ovf_fd", frame_done, 1);
    check("ovf_at_fd", overflow, 1);
    step(1'b0, 1'b0, 8'h00);
    check("ovf_fd_end", frame_done, 0);
    check("ovf_clear", overflow, 0);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h50); step(1'b0, 1'b1, 8'h00); step(1'b0, 1'b1, 8'h60);
    step(1'b0, 1'b1, 8'h00); step(1'b0, 1'b1, 8'h70); step(1'b0, 1'b1, 8'h80);
    check("ar_pre_en", out_en, 1);
    check("ar_pre_addr", f_addr, 1);
    check("ar_pre_data", f_data, 12'h600);
    #2 rst = 1'b1;
    #1;
    check("ar_en", out_en, 0);
    check("ar_addr", f_addr, 0);
    check("ar_data", f_data, 0);
    step(1'b0, 1'b0, 8'h00); step(1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    b = wa.size(); f = n_fd;
    pix_line(0, 4); pulse();
    pix_line(0, 4); pulse();
    check("ar_skip_writes", wa.size() - b, 0);
    check("ar_skip_fd", n_fd - f, 0);
    pix_line(0, 3); pulse();
    check("ar_cap_writes", wa.size() - b, 3);
    check("ar_cap_fd", n_fd - f, 1);
    check("ar_cap_addr", wa[b + 2], 2);
`ifdef CAP_LINE_CHECK_EN
    pix_line(0, 4);
    check("lc_ok", line_err, 0);
    pix_line(0, 3);
    check("lc_short", line_err, 1);
    repeat (3) step(1'b1, 1'b0, 8'h00);
    check("lc_hold", line_err, 1);
    repeat (3) step(1'b0, 1'b0, 8'h00);
    check("lc_clear", line_err, 0);
`else
    pix_line(0, 3);
    check("lc_tied", line_err, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
